// File: rtl/rx_timer_pkg.sv
// Shared types, default timing constants and a width helper for the receive bit timer.
//   rx_state_e     : controller state encoding (IDLE, RUN, ERR), 2 bits
//   DEF_*          : default timing parameters for rx_bit_timer
//   cnt_width(n)   : bits needed to hold values 0..n-1 (minimum 1)
package rx_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } rx_state_e;

    localparam int unsigned DEF_CLKS_PER_BIT  = 8;
    localparam int unsigned DEF_SAMPLE_PHASE  = 3;
    localparam int unsigned DEF_BITS_PER_WORD = 8;
    localparam int unsigned DEF_MAX_RUN       = 6;

    // Counter width for a modulus of n; never returns 0 so ports stay legal.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_counter.sv
// Parametrised up-counter with synchronous clear and programmable rollover.
//   clk, rst      : clock and synchronous active-high reset
//   clear         : force count to 0 (wins over enable)
//   enable        : advance by one; wraps to 0 after reaching rollover_val
//   rollover_val  : last value before wrap
//   count         : registered count value
module sync_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic [WIDTH-1:0] count
);

    // Count register: reset, then clear, then increment-with-wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == rollover_val) begin
                count <= '0;
            end else begin
                count <= count + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/rx_bit_timer.sv
// Receive bit timer: recovers a sample strobe from an oversampled line (re-phased on
// every data edge), counts bits into words while dropping stuffed bits, and flags an
// over-long edge-free run as a sticky error until the packet ends.
//   clk, rst      : clock, synchronous active-high reset
//   rcving        : packet in progress; low returns to IDLE and clears counters
//   d_edge        : one-cycle line-transition pulse, re-phases the bit clock
//   stuff_skip    : current sample is a stuffed bit and is not counted
//   shift_enable  : sample strobe, one cycle per bit period
//   bit_valid     : counted bit (shift_enable without stuff_skip)
//   word_done     : last counted bit of a word
//   bit_count     : counted bits in the current word
//   run_err       : sticky stuffing-violation flag
//   busy          : state is RUN or ERR
module rx_bit_timer
    import rx_timer_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT  = DEF_CLKS_PER_BIT,
    parameter int unsigned SAMPLE_PHASE  = DEF_SAMPLE_PHASE,
    parameter int unsigned BITS_PER_WORD = DEF_BITS_PER_WORD,
    parameter int unsigned MAX_RUN       = DEF_MAX_RUN
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                rcving,
    input  logic                                d_edge,
    input  logic                                stuff_skip,
    output logic                                shift_enable,
    output logic                                bit_valid,
    output logic                                word_done,
    output logic [cnt_width(BITS_PER_WORD)-1:0] bit_count,
    output logic                                run_err,
    output logic                                busy
);

    localparam int unsigned PH_W  = cnt_width(CLKS_PER_BIT);
    localparam int unsigned RUN_W = cnt_width(MAX_RUN + 1);
    localparam int unsigned BC_W  = cnt_width(BITS_PER_WORD);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_ERR  = ST_ERR;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [PH_W-1:0]  phase_q;
    logic [RUN_W-1:0] run_q;

    logic in_idle;
    logic in_run;
    logic run_viol;
    logic cnt_clear;
    logic edge_clear;
    logic run_inc;

    // State decodes.
    assign in_idle = (state_q == S_IDLE);
    assign in_run  = (state_q == S_RUN);

    // Strobe and word framing, decoded from registered phase and bit count.
    assign shift_enable = in_run & (phase_q == PH_W'(SAMPLE_PHASE));
    assign bit_valid    = shift_enable & ~stuff_skip;
    assign word_done    = bit_valid & (bit_count == BC_W'(BITS_PER_WORD - 1));

    // A sample taken with the run counter already at its limit is a violation.
    assign run_viol = shift_enable & (run_q == RUN_W'(MAX_RUN));

    assign run_err = (state_q == S_ERR);
    assign busy    = ~in_idle;

    // Counters restart whenever the packet is not (or no longer) active, so a dropped
    // rcving discards the partial word by the very next cycle.
    assign cnt_clear  = in_idle | ~rcving;
    // Edges only re-phase while running; in ERR they are ignored.
    assign edge_clear = cnt_clear | (in_run & d_edge);
    // The violating sample must not push run past MAX_RUN; ERR freezes it there.
    assign run_inc    = shift_enable & ~run_viol;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; rcving low outranks the violation transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (rcving) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!rcving) begin
                    state_d = S_IDLE;
                end else if (run_viol) begin
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                if (!rcving) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bit phase within the line bit; free-runs in RUN, forced to 0 by an edge.
    sync_counter #(
        .WIDTH(PH_W)
    ) u_phase (
        .clk          (clk),
        .rst          (rst),
        .clear        (edge_clear),
        .enable       (in_run),
        .rollover_val (PH_W'(CLKS_PER_BIT - 1)),
        .count        (phase_q)
    );

    // Samples since the last edge; the edge clear wins over a same-cycle sample.
    sync_counter #(
        .WIDTH(RUN_W)
    ) u_run (
        .clk          (clk),
        .rst          (rst),
        .clear        (edge_clear),
        .enable       (run_inc),
        .rollover_val (RUN_W'(MAX_RUN)),
        .count        (run_q)
    );

    // Counted bits in the current word; wraps after the word_done bit.
    sync_counter #(
        .WIDTH(BC_W)
    ) u_bit (
        .clk          (clk),
        .rst          (rst),
        .clear        (cnt_clear),
        .enable       (bit_valid),
        .rollover_val (BC_W'(BITS_PER_WORD - 1)),
        .count        (bit_count)
    );

endmodule

// File: tb/tb_rx_bit_timer.sv
// Directed self-checking bench for rx_bit_timer at default timing (8 clk/bit,
// sample phase 3, 8-bit words, max run 6).
module tb_rx_bit_timer;

    localparam int CPB = 8;
    localparam int SP  = 3;
    localparam int BPW = 8;
    localparam int MR  = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rcving = 1'b0;
    logic       d_edge = 1'b0;
    logic       stuff_skip = 1'b0;
    logic       shift_enable;
    logic       bit_valid;
    logic       word_done;
    logic [2:0] bit_count;
    logic       run_err;
    logic       busy;

    int n_chk = 0;
    int n_bad = 0;
    int cyc_n = 0;

    rx_bit_timer #(
        .CLKS_PER_BIT  (CPB),
        .SAMPLE_PHASE  (SP),
        .BITS_PER_WORD (BPW),
        .MAX_RUN       (MR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rcving       (rcving),
        .d_edge       (d_edge),
        .stuff_skip   (stuff_skip),
        .shift_enable (shift_enable),
        .bit_valid    (bit_valid),
        .word_done    (word_done),
        .bit_count    (bit_count),
        .run_err      (run_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %0d, want %0d", tag, cyc_n, got, exp);
        end
    endtask

    // One clock cycle: inputs applied just after the rising edge, outputs observed
    // at the falling edge of the same cycle.
    task automatic cyc(input logic rs, input logic r, input logic e, input logic s);
        @(posedge clk);
        #1;
        cyc_n++;
        rst        = rs;
        rcving     = r;
        d_edge     = e;
        stuff_skip = s;
        @(negedge clk);
    endtask

    // Leave any state, pass through IDLE, and return with the next cycle being the
    // first RUN cycle (phase 0).
    task automatic enter_run();
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // Edge every bit period, sample 4 cycles after each edge; optional stuffed bit.
    task automatic word_run(input string tag, input int n_sh, input int skip_at,
                            input int exp_bv, input int exp_wd);
        int   cnt  = 0;
        int   n_bv = 0;
        int   n_wd = 0;
        logic sh;
        logic sk;
        enter_run();
        for (int k = 0; k < n_sh * 8 + 2; k++) begin
            sh = (k % 8 == 4);
            sk = sh && (k / 8 == skip_at);
            cyc(1'b0, 1'b1, (k % 8 == 0), sk);
            chk({tag, "_se"}, 32'(shift_enable), 32'(sh));
            chk({tag, "_bv"}, 32'(bit_valid), 32'(sh && !sk));
            chk({tag, "_wd"}, 32'(word_done), 32'(sh && !sk && cnt == BPW - 1));
            chk({tag, "_bc"}, 32'(bit_count), 32'(cnt));
            if (sh && !sk) cnt = (cnt + 1) % BPW;
            n_bv += int'(bit_valid);
            n_wd += int'(word_done);
        end
        chk({tag, "_nbv"}, 32'(n_bv), 32'(exp_bv));
        chk({tag, "_nwd"}, 32'(n_wd), 32'(exp_wd));
    endtask

    // Single edge then silence: the 7th sample (k=52) violates, ERR from k=53.
    task automatic run_violation();
        logic sh;
        enter_run();
        for (int k = 0; k <= 70; k++) begin
            sh = (k <= 52) && (k % 8 == 4);
            cyc(1'b0, 1'b1, (k == 0 || k == 60), 1'b0);
            chk("viol_se", 32'(shift_enable), 32'(sh));
            chk("viol_bv", 32'(bit_valid), 32'(sh));
            chk("viol_wd", 32'(word_done), 32'(0));
            chk("viol_err", 32'(run_err), 32'(k >= 53));
            chk("viol_busy", 32'(busy), 32'(1));
            if (k >= 53) begin
                chk("viol_bc_frozen", 32'(bit_count), 32'(7));
                chk("viol_run_frozen", 32'(dut.run_q), 32'(MR));
            end
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("viol_err_hold", 32'(run_err), 32'(1));
        chk("viol_busy_hold", 32'(busy), 32'(1));
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("viol_err_clr", 32'(run_err), 32'(0));
        chk("viol_busy_clr", 32'(busy), 32'(0));
        chk("viol_bc_clr", 32'(bit_count), 32'(0));
    endtask

    // Edge on the same cycle as a sample, with run already at 1.
    task automatic edge_on_sample();
        enter_run();
        for (int k = 0; k <= 16; k++) begin
            cyc(1'b0, 1'b1, (k == 0 || k == 12), 1'b0);
            if (k == 12) begin
                chk("es_se", 32'(shift_enable), 32'(1));
                chk("es_run_pre", 32'(dut.run_q), 32'(1));
            end
            if (k == 13) begin
                chk("es_run", 32'(dut.run_q), 32'(0));
                chk("es_phase", 32'(dut.phase_q), 32'(0));
            end
            if (k == 16) chk("es_se_next", 32'(shift_enable), 32'(1));
        end
    endtask

    // Edge while phase is at its last value.
    task automatic edge_at_wrap();
        enter_run();
        for (int k = 0; k <= 13; k++) begin
            cyc(1'b0, 1'b1, (k == 0 || k == 8), 1'b0);
            if (k == 8)  chk("ew_phase7", 32'(dut.phase_q), 32'(CPB - 1));
            if (k == 9)  chk("ew_phase0", 32'(dut.phase_q), 32'(0));
            if (k == 11) chk("ew_se_early", 32'(shift_enable), 32'(0));
            if (k == 12) chk("ew_se", 32'(shift_enable), 32'(1));
            if (k == 13) chk("ew_se_off", 32'(shift_enable), 32'(0));
        end
    endtask

    // Abort mid-word at bit_count 5, by rcving drop or by rst.
    task automatic abort_at5(input string tag, input logic use_rst);
        logic ab;
        enter_run();
        for (int k = 0; k <= 38; k++) begin
            ab = (k == 38);
            cyc(ab && use_rst, !(ab && !use_rst), (k % 8 == 0), 1'b0);
            chk({tag, "_wd"}, 32'(word_done), 32'(0));
            if (ab) chk({tag, "_bc5"}, 32'(bit_count), 32'(5));
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk({tag, "_bc"}, 32'(bit_count), 32'(0));
        chk({tag, "_phase"}, 32'(dut.phase_q), 32'(0));
        chk({tag, "_run"}, 32'(dut.run_q), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_wd_after"}, 32'(word_done), 32'(0));
        word_run({tag, "_next"}, 8, -1, 8, 1);
    endtask

    initial begin
        // Reset held with rcving/d_edge high: reset must win.
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_se", 32'(shift_enable), 32'(0));
        chk("rst_bv", 32'(bit_valid), 32'(0));
        chk("rst_wd", 32'(word_done), 32'(0));
        chk("rst_bc", 32'(bit_count), 32'(0));
        chk("rst_err", 32'(run_err), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t1_busy5", 32'(busy), 32'(0));
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t1_busy6", 32'(busy), 32'(1));
        chk("t1_phase6", 32'(dut.phase_q), 32'(0));
        while (cyc_n < 30) begin
            cyc(1'b0, 1'b1, (cyc_n + 1 == 10), 1'b0);
            if (cyc_n >= 10)
                chk("t1_se", 32'(shift_enable),
                    32'(cyc_n == 14 || cyc_n == 22 || cyc_n == 30));
        end

        word_run("word", 8, -1, 8, 1);
        word_run("stuff", 9, 2, 8, 1);
        run_violation();
        edge_on_sample();
        edge_at_wrap();
        abort_at5("drop", 1'b0);
        abort_at5("rst", 1'b1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete (cycle %0d)", cyc_n);
        $fatal(1);
    end

endmodule

// File: doc/rx_bit_timer.md
Name: rx_bit_timer

Overview:
Parametrised bit-timing and word-framing block for the serial receive path. It recovers a sample strobe from an oversampled line, re-phasing on every data edge. It counts received bits into words of configurable length and drops stuffed bits flagged by the decoder. It also detects an over-long run of edge-free bits (stuffing violation) and reports it as a sticky error until the packet ends.

Parameters:
CLKS_PER_BIT, 8, clk cycles per line bit (>=4)
SAMPLE_PHASE, 3, phase value at which the bit is sampled (0..CLKS_PER_BIT-1)
BITS_PER_WORD, 8, counted bits per word (>=2)
MAX_RUN, 6, max consecutive samples without an intervening d_edge before a stuffing violation

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
rcving  in  1  packet in progress; low forces IDLE
d_edge  in  1  one-cycle pulse, line transition detected
stuff_skip  in  1  decoder flag: bit sampled this cycle is a stuffed bit, do not count it
shift_enable  out  1  sample strobe; one cycle per bit period
bit_valid  out  1  shift_enable and not stuff_skip (counted bit)
word_done  out  1  one-cycle pulse on the last counted bit of a word
bit_count  out  $clog2(BITS_PER_WORD)  counted bits in current word
run_err  out  1  sticky stuffing-violation flag
busy  out  1  state is RUN or ERR

Behaviour:
- Reset: rst high at a clock edge sets state=IDLE and phase/run/bit counters=0. All outputs are then 0. rst dominates every other input, including mid-packet.
- States: IDLE, RUN, ERR.
- IDLE -> RUN when rcving=1; phase=0 on the next cycle.
- RUN -> IDLE when rcving=0.
- RUN -> ERR on a run violation.
- ERR -> IDLE when rcving=0. rcving=0 takes priority over every other RUN transition.
- Phase counter, RUN only: increments each cycle and wraps CLKS_PER_BIT-1 -> 0.
- d_edge in cycle t forces phase=0 in cycle t+1, overriding increment and wrap. d_edge in IDLE or ERR is ignored.
- shift_enable is decoded from registered phase: high in RUN when phase==SAMPLE_PHASE. It is still asserted if d_edge arrives in that same cycle.
- Latency: d_edge at cycle t gives shift_enable at t+1+SAMPLE_PHASE. Without further edges, it repeats every CLKS_PER_BIT cycles.
- bit_valid = shift_enable & ~stuff_skip. stuff_skip outside a shift_enable cycle has no effect.
- bit_count advances on bit_valid.
- word_done = bit_valid & (bit_count==BITS_PER_WORD-1). In that cycle bit_count wraps to 0 on the next edge.
- Run counter: cleared by d_edge (the clear wins over a simultaneous shift_enable) and incremented on each shift_enable.
- A shift_enable while run==MAX_RUN is a violation. run_err goes high the next cycle and state goes to ERR.
- The violating sample is not suppressed; its shift_enable and bit_valid still assert.
- ERR: shift_enable, bit_valid and word_done are held 0. Counters are frozen. run_err stays 1 until the state returns to IDLE, then clears.
- rcving drop mid-word: partial word discarded, no word_done, bit_count=0 in the next cycle.
- Counter widths: phase is $clog2(CLKS_PER_BIT); run is $clog2(MAX_RUN+1). No overflow is possible given the wrap and clear rules.

Decomposition:
- Package rx_timer_pkg holds:
  - the state enum (IDLE, RUN, ERR), 2-bit encoding
  - default timing constants
  - a width helper function
- One natural sub-module: sync_counter, a parametrised up-counter instantiated three times (phase, run, bit). Its ports are clear, enable and rollover_val, with a synchronous active-high reset.

Test Plan:
1. Defaults, rst for 2 cycles, then rcving=1 at cycle 5 and d_edge at cycle 10 -> shift_enable at cycles 14, 22 and 30. busy goes to 1 at cycle 6.
2. d_edge every 8 cycles plus 8 bit periods, stuff_skip=0 -> 8 bit_valid pulses. bit_count steps 0..7 and word_done coincides with the 8th pulse. bit_count=0 the next cycle.
3. stuff_skip=1 on the 3rd shift_enable of a word -> that cycle has shift_enable=1 and bit_valid=0. word_done comes on the 9th shift_enable.
4. No d_edge for 7 bit periods after an edge -> 7th shift_enable is the violation. run_err=1 from the next cycle and shift_enable then stays 0. rcving=0 -> IDLE and run_err=0 next cycle.
5. Boundary cases, each checked separately:
   - d_edge on the same cycle as shift_enable -> strobe still asserted and run counter = 0.
   - d_edge at phase 7 -> phase = 0, not a wrap plus increment.
6. rcving drops at bit_count=5, and separately rst at bit_count=5 -> no word_done, all counters 0. The next packet starts its first word at bit_count 0.
